// File: rtl/i2c_arbiter.sv
// ============================================================================
// Module      : i2c_arbiter
// Description : Round-robin arbiter sharing one I2C master among N_REQ
//               requesters. Optional watchdog enabled by I2C_ARB_WDT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_arbiter #(
  parameter int N_REQ      = 2,
  parameter int WDT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_ena_i,
  input  logic [7*N_REQ-1:0]   req_addr_i,
  input  logic [N_REQ-1:0]     req_rw_i,
  input  logic [8*N_REQ-1:0]   req_data_wr_i,
  output logic [N_REQ-1:0]     req_busy_o,
  output logic [N_REQ-1:0]     grant_o,
  output logic                 i2c_ena_o,
  output logic [6:0]           i2c_addr_o,
  output logic                 i2c_rw_o,
  output logic [7:0]           i2c_data_wr_o,
  input  logic                 i2c_busy_i,
  output logic                 wdt_err_o
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_ACTIVE    = 2'd2
  } state_e;

  if (N_REQ < 2 || N_REQ > 8 || WDT_CYCLES < 1) begin : g_param_check
    $error("i2c_arbiter: N_REQ must be 2..8 and WDT_CYCLES at least 1");
  end

  state_e          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [OW-1:0]   owner_inc;
  logic [OW-1:0]   pick;
  logic            pick_vld;
  logic            owner_ena;
  logic            granted;

  assign granted   = (state_q == S_WAIT_BUSY) || (state_q == S_ACTIVE);
  assign owner_ena = req_ena_i[owner_q];
  assign owner_inc = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + OW'(1);

  // Scan downward so the candidate closest to ptr is the one left standing.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_ena_i[OW'((int'(ptr_q) + k) % N_REQ)]) begin
        pick_vld = 1'b1;
        pick     = OW'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    grant_o       = '0;
    i2c_ena_o     = 1'b0;
    i2c_addr_o    = '0;
    i2c_rw_o      = 1'b0;
    i2c_data_wr_o = '0;
    if (granted) begin
      grant_o[owner_q] = 1'b1;
      i2c_ena_o        = owner_ena;
      i2c_addr_o       = req_addr_i[int'(owner_q)*7 +: 7];
      i2c_rw_o         = req_rw_i[owner_q];
      i2c_data_wr_o    = req_data_wr_i[int'(owner_q)*8 +: 8];
    end
  end

  assign req_busy_o = grant_o & {N_REQ{i2c_busy_i}};

`ifdef I2C_ARB_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);

  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             wdt_err_q, wdt_err_d;
  logic             wdt_hit;

  assign wdt_hit   = granted && (wdt_q == WDT_W'(WDT_CYCLES - 1));
  assign wdt_err_o = wdt_err_q;
`else
  assign wdt_err_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld && !i2c_busy_i) begin
          state_d = S_WAIT_BUSY;
          owner_d = pick;
        end
      end
      S_WAIT_BUSY: begin
        if (i2c_busy_i) begin
          state_d = S_ACTIVE;
        end else if (!owner_ena) begin
          state_d = S_IDLE;
          ptr_d   = owner_inc;
        end
      end
      S_ACTIVE: begin
        // Busy low with ena still high is a chained-byte boundary: keep grant.
        if (!i2c_busy_i && !owner_ena) begin
          state_d = S_IDLE;
          ptr_d   = owner_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef I2C_ARB_WDT_EN
    wdt_err_d = 1'b0;
    if (wdt_hit) begin
      state_d   = S_IDLE;
      ptr_d     = owner_inc;
      wdt_err_d = 1'b1;
    end
    wdt_d = (state_d != state_q || !granted) ? '0 : wdt_q + WDT_W'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef I2C_ARB_WDT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_q     <= '0;
      wdt_err_q <= 1'b0;
    end else begin
      wdt_q     <= wdt_d;
      wdt_err_q <= wdt_err_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_i2c_arbiter.sv
// ============================================================================
// Module      : tb_i2c_arbiter
// Description : Directed and random checks of i2c_arbiter against a
//               cycle reference model; watchdog part under I2C_ARB_WDT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_arbiter;
  localparam int N   = 4;
  localparam int WDT = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_ena;
  logic [7*N-1:0] req_addr;
  logic [N-1:0]   req_rw;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_busy, grant;
  logic           i2c_ena, i2c_rw, i2c_busy, wdt_err;
  logic [6:0]     i2c_addr;
  logic [7:0]     i2c_data;

  always #5 clk = ~clk;

  i2c_arbiter #(.N_REQ(N), .WDT_CYCLES(WDT)) dut (
    .clk(clk), .rst(rst),
    .req_ena_i(req_ena), .req_addr_i(req_addr), .req_rw_i(req_rw),
    .req_data_wr_i(req_data), .req_busy_o(req_busy), .grant_o(grant),
    .i2c_ena_o(i2c_ena), .i2c_addr_o(i2c_addr), .i2c_rw_o(i2c_rw),
    .i2c_data_wr_o(i2c_data), .i2c_busy_i(i2c_busy), .wdt_err_o(wdt_err)
  );

  int n_assert = 0, n_fail = 0;

  // Reference model: owner index (-1 = nobody), accepted = master took it.
  int m_owner = -1, m_ptr = 0, m_cnt = 0;
  bit m_acc = 0, m_err = 0;

  // Bench master: delay before busy, busy length, dead = never answers.
  int ms_dly = 2, ms_len = 4, ms_dcnt = 0, ms_bcnt = 0;
  bit ms_dead = 0;

  int       bytes_left [N];
  logic [N-1:0] rb_s, rb_prev, g_s;
  logic     ena_s;
  bit       rand_on = 0, gap_chk = 0;
  int       zero_run = 0;
  logic [N-1:0] last_g = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs;
    logic [N-1:0] eg;
    logic         ee, er;
    logic [6:0]   ea;
    logic [7:0]   ed;
    eg = '0; ee = 0; er = 0; ea = '0; ed = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ee = req_ena[m_owner];
      er = req_rw[m_owner];
      ea = req_addr[m_owner*7 +: 7];
      ed = req_data[m_owner*8 +: 8];
    end
    chk("grant",    32'(grant),    32'(eg));
    chk("i2c_ena",  32'(i2c_ena),  32'(ee));
    chk("i2c_addr", 32'(i2c_addr), 32'(ea));
    chk("i2c_rw",   32'(i2c_rw),   32'(er));
    chk("i2c_data", 32'(i2c_data), 32'(ed));
    chk("req_busy", 32'(req_busy), 32'(eg & {N{i2c_busy}}));
    chk("wdt_err",  32'(wdt_err),  32'(m_err));
  endtask

  task automatic model_next(output int no, output int np, output int nc,
                            output bit na, output bit ne);
    bit oe, rel;
    no = m_owner; np = m_ptr; nc = m_cnt; na = m_acc; ne = 0; rel = 0;
    if (rst) begin
      no = -1; np = 0; nc = 0; na = 0;
    end else if (m_owner < 0) begin
      na = 0; nc = 0;
      if (req_ena != 0 && !i2c_busy)
        for (int k = N - 1; k >= 0; k--)
          if (req_ena[(m_ptr + k) % N]) no = (m_ptr + k) % N;
    end else begin
      oe = req_ena[m_owner];
      if (!m_acc) begin
        if (i2c_busy) begin na = 1; nc = 0; end
        else if (!oe) rel = 1;
        else nc = m_cnt + 1;
      end else begin
        if (!i2c_busy && !oe) rel = 1;
        else nc = m_cnt + 1;
      end
`ifdef I2C_ARB_WDT_EN
      if (m_cnt == WDT - 1) begin rel = 1; ne = 1; end
`endif
      if (rel) begin no = -1; np = (m_owner + 1) % N; nc = 0; na = 0; end
    end
  endtask

  task automatic master_tick;
    if (i2c_busy) begin
      ms_bcnt--;
      if (ms_bcnt <= 0) i2c_busy = 1'b0;
    end else if (ms_dcnt > 0) begin
      ms_dcnt--;
      if (ms_dcnt == 0) begin i2c_busy = 1'b1; ms_bcnt = ms_len; end
    end else if (ena_s && !ms_dead) begin
      ms_dcnt = ms_dly;
    end
  endtask

  task automatic requester_tick;
    for (int i = 0; i < N; i++) begin
      if (rb_s[i] && !rb_prev[i] && req_ena[i]) begin
        bytes_left[i]--;
        if (bytes_left[i] <= 0) req_ena[i] = 1'b0;
      end else if (rand_on && req_ena[i] && g_s[i] && !rb_s[i] && $urandom_range(31) == 0) begin
        req_ena[i] = 1'b0;
      end else if (rand_on && !req_ena[i] && $urandom_range(7) == 0) begin
        req_ena[i]           = 1'b1;
        bytes_left[i]        = 1 + int'($urandom_range(1));
        req_addr[i*7 +: 7]   = 7'($urandom);
        req_rw[i]            = 1'($urandom);
        req_data[i*8 +: 8]   = 8'($urandom);
      end
    end
    if (rand_on) begin
      ms_dly = 1 + int'($urandom_range(2));
      ms_len = 2 + int'($urandom_range(5));
    end
  endtask

  task automatic step;
    int no, np, nc;
    bit na, ne;
    @(negedge clk);
    check_outputs();
    if (gap_chk) begin
      if (grant != 0 && last_g == 0 && zero_run > 0) chk("idle_gap", 32'(zero_run), 32'd1);
      zero_run = (grant == 0) ? zero_run + 1 : 0;
      last_g   = grant;
    end
    ena_s = i2c_ena; rb_prev = rb_s; rb_s = req_busy; g_s = grant;
    model_next(no, np, nc, na, ne);
    @(posedge clk);
    #1;
    m_owner = no; m_ptr = np; m_cnt = nc; m_acc = na; m_err = ne;
    master_tick();
    requester_tick();
  endtask

  task automatic run_until_idle(input int max);
    int w;
    w = 0;
    while ((m_owner >= 0 || req_ena != 0 || i2c_busy) && w < max) begin
      step();
      w++;
    end
    n_assert++;
    assert (w < max) else begin
      n_fail++;
      $error("FAIL timeout: observed %0d cycles expected fewer than %0d", w, max);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_ena = '0; req_addr = '0; req_rw = '0; req_data = '0;
    i2c_busy = 1'b0; rb_s = '0; rb_prev = '0; g_s = '0; ena_s = 1'b0;
    for (int i = 0; i < N; i++) bytes_left[i] = 0;
    do_reset();

    // Requester 1 reads 0x38, master busy for 40 cycles.
    ms_dly = 2; ms_len = 40;
    req_addr[7 +: 7] = 7'h38; req_rw[1] = 1'b1; req_data[8 +: 8] = 8'h5C;
    req_ena[1] = 1'b1; bytes_left[1] = 1;
    step();
    chk("t1_grant", 32'(grant), 32'h2);
    chk("t1_addr",  32'(i2c_addr), 32'h38);
    chk("t1_rw",    32'(i2c_rw), 32'h1);
    run_until_idle(100);

    // Simultaneous requests after reset: 0 first, 1 after one idle cycle.
    do_reset();
    ms_dly = 1; ms_len = 5;
    req_ena = 4'b0011; bytes_left[0] = 1; bytes_left[1] = 1;
    gap_chk = 1; zero_run = 0; last_g = '0;
    step();
    chk("t2_first", 32'(grant), 32'h1);
    run_until_idle(100);
    gap_chk = 0;

    // Two-byte write by requester 2: grant held across the byte boundary.
    req_addr[14 +: 7] = 7'h29; req_rw[2] = 1'b0; req_data[16 +: 8] = 8'hA5;
    req_ena[2] = 1'b1; bytes_left[2] = 2; ms_len = 6;
    run_until_idle(100);

    // Reset mid-transfer with a pending request.
    ms_len = 20;
    req_ena[0] = 1'b1; bytes_left[0] = 1;
    for (int i = 0; i < 10 && !(m_acc && i2c_busy); i++) step();
    req_ena[0] = 1'b0; req_ena[3] = 1'b1; bytes_left[3] = 1; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_grant", 32'(grant), 32'h0);
    chk("t4_ena",   32'(i2c_ena), 32'h0);
    run_until_idle(100);

`ifdef I2C_ARB_WDT_EN
    // Dead master: watchdog aborts the owner and the next one is granted.
    ms_dead = 1;
    req_ena[0] = 1'b1; req_ena[1] = 1'b1; bytes_left[0] = 1; bytes_left[1] = 1;
    repeat (3 * WDT) step();
    req_ena = '0; ms_dead = 0;
    run_until_idle(100);
`endif

    // Random traffic from all requesters.
    do_reset();
    rand_on = 1;
    repeat (3000) step();
    rand_on = 0;
    for (int i = 0; i < N; i++) bytes_left[i] = 1;
    req_ena = '0;
    run_until_idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
